// File: rtl/multiplier.sv
// multiplier: pipelined Q10.22 signed multiply with saturation, 2-cycle latency
module multiplier (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        out_valid,
    output logic        overflow
);
    logic [31:0] a_q, b_q, out_q, out_d;
    logic        v1_q, vo_q, ovf_q, ovf_d;
    logic signed [31:0] hh;
    logic signed [32:0] hl, lh;
    logic [31:0] ll;
    logic [63:0] p;
    // four DSP-sized partial products recombined into the full 64-bit product, then saturated
    always_comb begin
        hh = 32'($signed(a_q[31:16])) * 32'($signed(b_q[31:16]));
        hl = 33'($signed(a_q[31:16])) * 33'($signed({1'b0, b_q[15:0]}));
        lh = 33'($signed({1'b0, a_q[15:0]})) * 33'($signed(b_q[31:16]));
        ll = 32'(a_q[15:0]) * 32'(b_q[15:0]);
        p = {hh, 32'b0} + {{15{hl[32]}}, hl, 16'b0} + {{15{lh[32]}}, lh, 16'b0} + {32'b0, ll};
        ovf_d = !((&p[63:53]) || !(|p[63:53]));
        out_d = ovf_d ? (p[63] ? 32'h8000_0000 : 32'h7FFF_FFFF) : p[53:22];
    end
    // input stage: capture operands and their valid
    always_ff @(posedge clk) begin
        if (reset) v1_q <= 1'b0;
        else v1_q <= in_valid;
        a_q <= a;
        b_q <= b;
    end
    // output stage: register result, holding it when no new operation arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            vo_q  <= 1'b0;
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            vo_q <= v1_q;
            if (v1_q) begin
                out_q <= out_d;
                ovf_q <= ovf_d;
            end
        end
    end
    assign out       = out_q;
    assign out_valid = vo_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: random and directed checks of multiplier against an arithmetic model
module tb_multiplier;
    logic        clk = 1'b0;
    logic        reset, in_valid;
    logic [31:0] a, b, out;
    logic        out_valid, overflow;
    int checks = 0, errors = 0;
    logic        s1v = 1'b0;
    logic [31:0] s1a = '0, s1b = '0, m_out = '0;
    logic        m_vld = 1'b0, m_ovf = 1'b0;
    logic [32:0] r;
    logic [31:0] da[12] = '{32'h0020_0000, 32'h0070_0000, 32'hFFA0_0000, 32'h0080_0000,
                            32'hFFE0_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h4B00_0000,
                            32'hB500_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] db[12] = '{32'h0028_0000, 32'h0001_0000, 32'h0060_0000, 32'hFE80_0000,
                            32'hFF40_0000, 32'h0000_0001, 32'h0000_0001, 32'h0100_0000,
                            32'h0100_0000, 32'h8000_0000, 32'h0040_0000, 32'h0040_0000};

    multiplier dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
        .out(out), .out_valid(out_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint p, q, lim;
        lim = 64'sh7FFF_FFFF;
        p = longint'($signed(x)) * longint'($signed(y));
        q = p >>> 22;
        if (q > lim) return {1'b1, 32'h7FFF_FFFF};
        if (q < -lim - 1) return {1'b1, 32'h8000_0000};
        return {1'b0, q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rs, input logic v, input logic [31:0] x, input logic [31:0] y);
        reset = rs; in_valid = v; a = x; b = y;
        @(posedge clk);
        if (rs) begin
            m_vld = 1'b0; m_out = '0; m_ovf = 1'b0; s1v = 1'b0;
        end else begin
            m_vld = s1v;
            if (s1v) begin
                r = ref_mul(s1a, s1b);
                m_out = r[31:0];
                m_ovf = r[32];
            end
            s1v = v; s1a = x; s1b = y;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("out", out, m_out);
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        logic [31:0] x, y;
        step(1, 1, 32'h0100_0000, 32'h0100_0000);
        step(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, da[i], db[i]);
        for (int i = 0; i < 12; i++) step(0, 1, db[i], da[i]);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, da[i], db[i]);
            step(0, 0, 32'h1234_5678, 32'h0FED_CBA9);
            if (i % 3 == 0) step(0, 0, 0, 0);
        end
        step(0, 1, 32'h0040_0000, 32'h0040_0000);
        step(0, 1, 32'h4B00_0000, 32'h0100_0000);
        step(1, 1, 32'h0080_0000, 32'h0080_0000);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h0060_0000, 32'hFFA0_0000);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 4 != 0) begin
                x = 32'($signed(x) >>> $urandom_range(0, 16));
                y = 32'($signed(y) >>> $urandom_range(4, 20));
            end
            step(0, ($urandom_range(0, 3) != 0), x, y);
            if (i % 5 == 0) step(0, 1, y, x);
            if (i == 200) step(1, 1, x, y);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
